// File: rtl/spi_pkg.sv
// Shared frame layout, peripheral register map and controller state encoding
// for the SPI frame controller.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter shared by every timed phase; expire is high while the
// count sits at zero, so a load of N-1 gives a phase of exactly N cycles.
module spi_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/spi_frame_controller.sv
// SPI mode-0 master that turns each accepted request into one 16-bit frame
// (write flag, 7-bit address, 8-bit data) followed by commit clock pulses.
module spi_frame_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int CS_SETUP     = 4,
  parameter int CS_HOLD      = 4,
  parameter int CS_GAP       = 4,
  parameter int COMMIT_PULSE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  localparam int         CNT_W    = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP)) + 1;
  localparam logic [4:0] LAST_BIT = 5'(15 + COMMIT_PULSE);

  if (CLK_DIV < 3) begin : g_bad_clk_div
    $error("spi_frame_controller: CLK_DIV must be >= 3");
  end
  if (CS_SETUP < 3) begin : g_bad_cs_setup
    $error("spi_frame_controller: CS_SETUP must be >= 3");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_frame_controller: CS_HOLD must be >= 1");
  end
  if (CS_GAP < 3) begin : g_bad_cs_gap
    $error("spi_frame_controller: CS_GAP must be >= 3");
  end
  if (COMMIT_PULSE < 0 || COMMIT_PULSE > 16) begin : g_bad_commit
    $error("spi_frame_controller: COMMIT_PULSE must be within 0..16");
  end

  spi_state_t         state;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               accept;
  logic               expire;
  logic               load;
  logic [CNT_W-1:0]   load_val;

  assign accept = req_valid && req_ready;

  spi_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .expire  (expire)
  );

  // GAP is loaded one short: the IDLE cycle carrying done is the final
  // nCS-high cycle, so back-to-back frames see exactly CS_GAP high cycles.
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load     = 1'b1;
          load_val = CNT_W'(CS_SETUP - 1);
        end
      end
      ST_SETUP, ST_SHIFT_HI: begin
        if (expire) begin
          load     = 1'b1;
          load_val = CNT_W'(CLK_DIV - 1);
        end
      end
      ST_SHIFT_LO: begin
        if (expire) begin
          load     = 1'b1;
          load_val = (bit_cnt == LAST_BIT) ? CNT_W'(CS_HOLD - 1) : CNT_W'(CLK_DIV - 1);
        end
      end
      ST_HOLD: begin
        if (expire) begin
          load     = 1'b1;
          load_val = CNT_W'(CS_GAP - 2);
        end
      end
      default: begin
        load     = 1'b0;
        load_val = '0;
      end
    endcase
  end

  // Frame data path: zero fill on shift makes COPI drop to 0 after bit0.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg[RW_BIT]            <= req_write;
      shreg[ADDR_MSB:ADDR_LSB] <= req_addr;
      shreg[DATA_MSB:0]        <= req_data;
    end else if (state == ST_SHIFT_HI && expire) begin
      shreg <= shreg << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
      nCS       <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SETUP;
            bit_cnt   <= '0;
            nCS       <= 1'b0;
            SCLK      <= 1'b0;
            COPI      <= req_write;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (expire) begin
            state <= ST_SHIFT_HI;
            SCLK  <= 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (expire) begin
            state <= ST_SHIFT_LO;
            SCLK  <= 1'b0;
            COPI  <= shreg[FRAME_W-2];
          end
        end
        ST_SHIFT_LO: begin
          if (expire) begin
            if (bit_cnt == LAST_BIT) begin
              state <= ST_HOLD;
              COPI  <= 1'b0;
            end else begin
              state   <= ST_SHIFT_HI;
              bit_cnt <= bit_cnt + 1'b1;
              SCLK    <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (expire) begin
            state <= ST_GAP;
            nCS   <= 1'b1;
          end
        end
        ST_GAP: begin
          if (expire) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          SCLK      <= 1'b0;
          COPI      <= 1'b0;
          nCS       <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
